cpl_enqueue_arbiter: RTL and testbench
======================================

// Module: cpl_enqueue_arbiter
// PURPOSE
//  Shares one cpl_queue_manager enqueue interface (req/resp/commit) between PORTS requesters.
//  Round-robin arbitration on requests and commits; tag-based routing of responses back to the requester.
//  Per-port outstanding-op credit limit. Sits between DMA/completion sources and cpl_queue_manager.
// PARAMETERS
//  PORTS             4   number of requesters (>=2, power of 2)
//  QUEUE_INDEX_WIDTH 5   queue index width, matches manager
//  REQ_TAG_WIDTH     8   requester-side tag width
//  OP_TAG_WIDTH      8   manager op tag width ($clog2(OP_TABLE_SIZE) rounded)
//  MAX_OUTSTANDING   8   max in-flight ops per port (req accepted, not yet committed/failed)
//  PORT_SEL_WIDTH    $clog2(PORTS), derived; TAG_OUT_WIDTH = REQ_TAG_WIDTH+PORT_SEL_WIDTH, derived
// PORTS
//  clk                          in  1                      clock
//  rst                          in  1                      async active-high reset
//  enable                       in  1                      0: no new grants; in-flight ops complete
//  s_axis_enqueue_req_queue     in  PORTS*QUEUE_INDEX_WIDTH per-port target queue
//  s_axis_enqueue_req_tag       in  PORTS*REQ_TAG_WIDTH    per-port request tag
//  s_axis_enqueue_req_valid     in  PORTS                  per-port request valid
//  s_axis_enqueue_req_ready     out PORTS                  per-port request accept
//  m_axis_enqueue_req_queue     out QUEUE_INDEX_WIDTH      to manager
//  m_axis_enqueue_req_tag       out TAG_OUT_WIDTH          {port, req_tag}
//  m_axis_enqueue_req_valid     out 1
//  m_axis_enqueue_req_ready     in  1
//  s_axis_enqueue_resp_tag      in  TAG_OUT_WIDTH          from manager
//  s_axis_enqueue_resp_op_tag   in  OP_TAG_WIDTH
//  s_axis_enqueue_resp_full     in  1
//  s_axis_enqueue_resp_error    in  1
//  s_axis_enqueue_resp_valid    in  1
//  s_axis_enqueue_resp_ready    out 1
//  m_axis_enqueue_resp_tag      out REQ_TAG_WIDTH          shared data, low bits of resp tag
//  m_axis_enqueue_resp_op_tag   out OP_TAG_WIDTH
//  m_axis_enqueue_resp_full/error out 1 each
//  m_axis_enqueue_resp_valid    out PORTS                  one-hot, selected by tag port field
//  m_axis_enqueue_resp_ready    in  PORTS
//  s_axis_enqueue_commit_op_tag in  PORTS*OP_TAG_WIDTH
//  s_axis_enqueue_commit_valid  in  PORTS
//  s_axis_enqueue_commit_ready  out PORTS
//  m_axis_enqueue_commit_op_tag out OP_TAG_WIDTH          to manager (no backpressure)
//  m_axis_enqueue_commit_valid  out 1
//  outstanding                  out PORTS*($clog2(MAX_OUTSTANDING)+1) per-port in-flight count
// BEHAVIOUR
//  Reset: all valids/readies 0, counts 0, RR pointers 0, FSM IDLE, data outputs 0.
//  Request FSM: IDLE -> SEND when enable and any eligible port; eligible = valid && count<MAX_OUTSTANDING.
//   Grant = first eligible at/after rr_ptr; cycle of grant: s_req_ready[g]=1 (capture), register queue/tag.
//   SEND: m_req_valid=1 held, data stable until m_req_ready; then rr_ptr=g+1 (wraps PORTS-1->0), -> IDLE.
//   Latency request accept -> m_req_valid: 1 cycle; max throughput 1 req / 2 cycles.
//  Response path: combinational route; resp_valid[port]=s_resp_valid; s_resp_ready=m_resp_ready[port].
//  Commit: RR over commit_valid, own pointer; winner's ready=1 and m_commit_valid/op_tag registered (1 cycle).
//  Counts: +1 on request capture; -1 on commit grant for port; -1 on resp handshake with full|error.
//   Simultaneous +1 and -1 on same port: count unchanged. Decrement at 0: saturate, never wrap.
//  enable falling during SEND: current request completes; no new grants.
//  Async reset mid-SEND: request dropped; upstream requester must reissue.
// STRUCTURE
//  Package cpl_arb_pkg: PORT_SEL_WIDTH/TAG_OUT_WIDTH function, req_fsm_t {IDLE,SEND}.
//  Sub-module rr_arbiter #(PORTS): req vector, ptr -> one-hot grant + index; instanced twice (req, commit).
// TESTING
//  Ports 0,2 valid same cycle, rr_ptr=0 -> port0 sent first, port2 second; tags 0x005/0x205-style {port,tag}.
//  m_req_ready held 0 for 5 cycles -> m_req_valid stays 1, queue/tag unchanged, no other port readied.
//  resp tag={3,0x7A}, port3 ready=0 -> only resp_valid[3]=1, s_resp_ready=0 until port3 ready.
//  Port1 issues 8 reqs, no commit -> count=8, 9th req not readied; one commit -> count=7, 9th accepted.
//  Resp full=1 for port1 with concurrent port1 request capture -> count unchanged.
//  Assert rst while in SEND -> all outputs 0 next edge, counts 0, FSM IDLE.

Source files
------------

// File: rtl/cpl_arb_pkg.sv
// cpl_arb_pkg: shared widths and request FSM state type for cpl_enqueue_arbiter
package cpl_arb_pkg;
  function automatic int sel_width(input int ports);
    return $clog2(ports);
  endfunction
  function automatic int tag_out_width(input int req_tag_width, input int ports);
    return req_tag_width + sel_width(ports);
  endfunction
  typedef enum logic {IDLE, SEND} req_fsm_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks first set req bit at/after ptr, returns one-hot grant, index and any-request flag
module rr_arbiter
  import cpl_arb_pkg::*;
#(
  parameter int PORTS = 4,
  localparam int SW = sel_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [SW-1:0]    ptr,
  output logic [PORTS-1:0] grant,
  output logic [SW-1:0]    idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    for (int i = PORTS - 1; i >= 0; i--)
      if (req[SW'(ptr + SW'(i))]) idx = SW'(ptr + SW'(i));
  end
  assign any = |req;
  assign grant = any ? PORTS'(1) << idx : '0;
endmodule

// File: rtl/cpl_enqueue_arbiter.sv
// cpl_enqueue_arbiter: shares one enqueue req/resp/commit interface among PORTS requesters (rr req+commit, tag-routed resp, per-port credit counts)
module cpl_enqueue_arbiter
  import cpl_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int QUEUE_INDEX_WIDTH = 5,
  parameter int REQ_TAG_WIDTH = 8,
  parameter int OP_TAG_WIDTH = 8,
  parameter int MAX_OUTSTANDING = 8,
  localparam int PORT_SEL_WIDTH = sel_width(PORTS),
  localparam int TAG_OUT_WIDTH = tag_out_width(REQ_TAG_WIDTH, PORTS),
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0] s_axis_enqueue_req_queue,
  input  logic [PORTS*REQ_TAG_WIDTH-1:0]     s_axis_enqueue_req_tag,
  input  logic [PORTS-1:0]                   s_axis_enqueue_req_valid,
  output logic [PORTS-1:0]                   s_axis_enqueue_req_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0]       m_axis_enqueue_req_queue,
  output logic [TAG_OUT_WIDTH-1:0]           m_axis_enqueue_req_tag,
  output logic                               m_axis_enqueue_req_valid,
  input  logic                               m_axis_enqueue_req_ready,
  input  logic [TAG_OUT_WIDTH-1:0]           s_axis_enqueue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]            s_axis_enqueue_resp_op_tag,
  input  logic                               s_axis_enqueue_resp_full,
  input  logic                               s_axis_enqueue_resp_error,
  input  logic                               s_axis_enqueue_resp_valid,
  output logic                               s_axis_enqueue_resp_ready,
  output logic [REQ_TAG_WIDTH-1:0]           m_axis_enqueue_resp_tag,
  output logic [OP_TAG_WIDTH-1:0]            m_axis_enqueue_resp_op_tag,
  output logic                               m_axis_enqueue_resp_full,
  output logic                               m_axis_enqueue_resp_error,
  output logic [PORTS-1:0]                   m_axis_enqueue_resp_valid,
  input  logic [PORTS-1:0]                   m_axis_enqueue_resp_ready,
  input  logic [PORTS*OP_TAG_WIDTH-1:0]      s_axis_enqueue_commit_op_tag,
  input  logic [PORTS-1:0]                   s_axis_enqueue_commit_valid,
  output logic [PORTS-1:0]                   s_axis_enqueue_commit_ready,
  output logic [OP_TAG_WIDTH-1:0]            m_axis_enqueue_commit_op_tag,
  output logic                               m_axis_enqueue_commit_valid,
  output logic [PORTS*CW-1:0]                outstanding
);
  localparam int SW = PORT_SEL_WIDTH;
  req_fsm_t state;
  logic [PORTS-1:0] elig, rgrant, cgrant;
  logic [SW-1:0] rgidx, cgidx, rptr, cptr, gport, rport;
  logic rany, cany;
  logic [PORTS-1:0][CW-1:0] cnt, cnt_nxt;
  rr_arbiter #(.PORTS(PORTS)) u_req_arb (.req(elig), .ptr(rptr), .grant(rgrant), .idx(rgidx), .any(rany));
  rr_arbiter #(.PORTS(PORTS)) u_cmt_arb (.req(s_axis_enqueue_commit_valid), .ptr(cptr), .grant(cgrant), .idx(cgidx), .any(cany));
  assign s_axis_enqueue_req_ready = (state == IDLE && enable) ? rgrant : '0;
  assign s_axis_enqueue_commit_ready = cgrant;
  assign rport = s_axis_enqueue_resp_tag[TAG_OUT_WIDTH-1 -: SW];
  assign m_axis_enqueue_resp_valid = s_axis_enqueue_resp_valid ? PORTS'(1) << rport : '0;
  assign s_axis_enqueue_resp_ready = m_axis_enqueue_resp_ready[rport];
  assign m_axis_enqueue_resp_tag = s_axis_enqueue_resp_tag[REQ_TAG_WIDTH-1:0];
  assign m_axis_enqueue_resp_op_tag = s_axis_enqueue_resp_op_tag;
  assign m_axis_enqueue_resp_full = s_axis_enqueue_resp_full;
  assign m_axis_enqueue_resp_error = s_axis_enqueue_resp_error;
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [CW:0] up;
    logic [1:0] dn;
    assign elig[p] = s_axis_enqueue_req_valid[p] && cnt[p] < CW'(MAX_OUTSTANDING);
    assign up = {1'b0, cnt[p]} + {{CW{1'b0}}, s_axis_enqueue_req_ready[p] & s_axis_enqueue_req_valid[p]};
    assign dn = {1'b0, cgrant[p]} + {1'b0, m_axis_enqueue_resp_valid[p] & m_axis_enqueue_resp_ready[p] & (s_axis_enqueue_resp_full | s_axis_enqueue_resp_error)};
    assign cnt_nxt[p] = up > {{(CW-1){1'b0}}, dn} ? CW'(up - {{(CW-1){1'b0}}, dn}) : '0;
  end
  assign outstanding = cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= cnt_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_axis_enqueue_req_valid <= 1'b0;
      m_axis_enqueue_req_queue <= '0;
      m_axis_enqueue_req_tag <= '0;
      rptr <= '0;
      gport <= '0;
    end else if (state == IDLE) begin
      if (enable && rany) begin
        state <= SEND;
        m_axis_enqueue_req_valid <= 1'b1;
        m_axis_enqueue_req_queue <= s_axis_enqueue_req_queue[rgidx*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
        m_axis_enqueue_req_tag <= {rgidx, s_axis_enqueue_req_tag[rgidx*REQ_TAG_WIDTH +: REQ_TAG_WIDTH]};
        gport <= rgidx;
      end
    end else if (m_axis_enqueue_req_ready) begin
      state <= IDLE;
      m_axis_enqueue_req_valid <= 1'b0;
      rptr <= gport + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_enqueue_commit_valid <= 1'b0;
      m_axis_enqueue_commit_op_tag <= '0;
      cptr <= '0;
    end else begin
      m_axis_enqueue_commit_valid <= cany;
      if (cany) begin
        m_axis_enqueue_commit_op_tag <= s_axis_enqueue_commit_op_tag[cgidx*OP_TAG_WIDTH +: OP_TAG_WIDTH];
        cptr <= cgidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cpl_enqueue_arbiter.sv
// tb_cpl_enqueue_arbiter: directed and randomized checks of cpl_enqueue_arbiter against a queue/credit model
module tb_cpl_enqueue_arbiter;
  localparam int P = 4, QW = 5, RW = 8, OW = 8, TW = 10, CW = 4, MAXO = 8;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [P*QW-1:0] s_req_queue = '0;
  logic [P*RW-1:0] s_req_tag = '0;
  logic [P-1:0] s_req_valid = '0, s_req_ready;
  logic [QW-1:0] m_req_queue;
  logic [TW-1:0] m_req_tag;
  logic m_req_valid, m_req_ready = 1'b0;
  logic [TW-1:0] s_resp_tag = '0;
  logic [OW-1:0] s_resp_op_tag = '0;
  logic s_resp_full = 1'b0, s_resp_error = 1'b0, s_resp_valid = 1'b0, s_resp_ready;
  logic [RW-1:0] m_resp_tag;
  logic [OW-1:0] m_resp_op_tag;
  logic m_resp_full, m_resp_error;
  logic [P-1:0] m_resp_valid, m_resp_ready = '0;
  logic [P*OW-1:0] s_commit_op_tag = '0;
  logic [P-1:0] s_commit_valid = '0, s_commit_ready;
  logic [OW-1:0] m_commit_op_tag;
  logic m_commit_valid;
  logic [P*CW-1:0] outstanding;
  int checks = 0, passed = 0;
  int mc[P];
  int rp = 0, cp = 0;
  always #5 clk = ~clk;
  cpl_enqueue_arbiter dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_enqueue_req_queue(s_req_queue), .s_axis_enqueue_req_tag(s_req_tag),
    .s_axis_enqueue_req_valid(s_req_valid), .s_axis_enqueue_req_ready(s_req_ready),
    .m_axis_enqueue_req_queue(m_req_queue), .m_axis_enqueue_req_tag(m_req_tag),
    .m_axis_enqueue_req_valid(m_req_valid), .m_axis_enqueue_req_ready(m_req_ready),
    .s_axis_enqueue_resp_tag(s_resp_tag), .s_axis_enqueue_resp_op_tag(s_resp_op_tag),
    .s_axis_enqueue_resp_full(s_resp_full), .s_axis_enqueue_resp_error(s_resp_error),
    .s_axis_enqueue_resp_valid(s_resp_valid), .s_axis_enqueue_resp_ready(s_resp_ready),
    .m_axis_enqueue_resp_tag(m_resp_tag), .m_axis_enqueue_resp_op_tag(m_resp_op_tag),
    .m_axis_enqueue_resp_full(m_resp_full), .m_axis_enqueue_resp_error(m_resp_error),
    .m_axis_enqueue_resp_valid(m_resp_valid), .m_axis_enqueue_resp_ready(m_resp_ready),
    .s_axis_enqueue_commit_op_tag(s_commit_op_tag), .s_axis_enqueue_commit_valid(s_commit_valid),
    .s_axis_enqueue_commit_ready(s_commit_ready), .m_axis_enqueue_commit_op_tag(m_commit_op_tag),
    .m_axis_enqueue_commit_valid(m_commit_valid), .outstanding(outstanding)
  );
  function automatic int rr_pick(input logic [P-1:0] m, input int ptr);
    for (int i = 0; i < P; i++) if (m[(ptr + i) % P]) return (ptr + i) % P;
    return -1;
  endfunction
  function automatic logic [P-1:0] onehot(input int g);
    logic [P-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic send_ack;
    m_req_ready = 1'b1;
    step();
    m_req_ready = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    s_req_valid = '0; s_commit_valid = '0; s_resp_valid = 1'b0; m_req_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int p = 0; p < P; p++) mc[p] = 0;
    rp = 0; cp = 0;
  endtask
  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (m_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", m_req_valid); else passed++;
    checks++; if (m_commit_valid !== 1'b0) $display("FAIL reset_commit_valid: got %b want 0", m_commit_valid); else passed++;
    checks++; if (m_req_tag !== '0) $display("FAIL reset_req_tag: got %h want 0", m_req_tag); else passed++;
    checks++; if (m_req_queue !== '0) $display("FAIL reset_req_queue: got %h want 0", m_req_queue); else passed++;
    checks++; if (m_commit_op_tag !== '0) $display("FAIL reset_commit_op_tag: got %h want 0", m_commit_op_tag); else passed++;
    checks++; if (s_req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", s_req_ready); else passed++;
    checks++; if (outstanding !== '0) $display("FAIL reset_outstanding: got %h want 0", outstanding); else passed++;
    enable = 1'b1;
  endtask
  task automatic test_two_ports;
    s_req_tag[0 +: RW] = 8'h05; s_req_tag[2*RW +: RW] = 8'h05;
    s_req_queue[0 +: QW] = 5'd1; s_req_queue[2*QW +: QW] = 5'd2;
    s_req_valid = 4'b0101;
    #1;
    checks++; if (s_req_ready !== 4'b0001) $display("FAIL two_first_ready: got %b want 0001", s_req_ready); else passed++;
    step();
    s_req_valid = 4'b0100;
    #1;
    checks++; if (m_req_valid !== 1'b1) $display("FAIL two_first_valid: got %b want 1", m_req_valid); else passed++;
    checks++; if (m_req_tag !== 10'h005) $display("FAIL two_first_tag: got %h want 005", m_req_tag); else passed++;
    checks++; if (m_req_queue !== 5'd1) $display("FAIL two_first_queue: got %h want 1", m_req_queue); else passed++;
    checks++; if (s_req_ready !== 4'b0000) $display("FAIL two_send_ready: got %b want 0000", s_req_ready); else passed++;
    send_ack(); mc[0]++; rp = 1;
    #1;
    checks++; if (m_req_valid !== 1'b0) $display("FAIL two_gap_valid: got %b want 0", m_req_valid); else passed++;
    checks++; if (s_req_ready !== 4'b0100) $display("FAIL two_second_ready: got %b want 0100", s_req_ready); else passed++;
    step();
    s_req_valid = '0;
    #1;
    checks++; if (m_req_tag !== 10'h205) $display("FAIL two_second_tag: got %h want 205", m_req_tag); else passed++;
    checks++; if (m_req_queue !== 5'd2) $display("FAIL two_second_queue: got %h want 2", m_req_queue); else passed++;
    send_ack(); mc[2]++; rp = 3;
  endtask
  task automatic test_stall;
    int g, g2;
    logic [TW-1:0] et;
    logic [QW-1:0] eq;
    s_req_tag[1*RW +: RW] = 8'h33; s_req_queue[1*QW +: QW] = 5'd7;
    s_req_tag[3*RW +: RW] = 8'hC3; s_req_queue[3*QW +: QW] = 5'd9;
    s_req_valid = 4'b1010;
    g = rr_pick(s_req_valid, rp);
    et = {2'(g), s_req_tag[g*RW +: RW]};
    eq = s_req_queue[g*QW +: QW];
    #1;
    checks++; if (s_req_ready !== onehot(g)) $display("FAIL stall_grant: got %b want %b", s_req_ready, onehot(g)); else passed++;
    step();
    repeat (5) begin
      #1;
      checks++; if (m_req_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", m_req_valid); else passed++;
      checks++; if (m_req_tag !== et) $display("FAIL stall_tag: got %h want %h", m_req_tag, et); else passed++;
      checks++; if (m_req_queue !== eq) $display("FAIL stall_queue: got %h want %h", m_req_queue, eq); else passed++;
      checks++; if (s_req_ready !== '0) $display("FAIL stall_other_ready: got %b want 0000", s_req_ready); else passed++;
      step();
    end
    send_ack(); mc[g]++; rp = (g + 1) % P;
    g2 = rr_pick(s_req_valid, rp);
    #1;
    checks++; if (s_req_ready !== onehot(g2)) $display("FAIL stall_next_grant: got %b want %b", s_req_ready, onehot(g2)); else passed++;
    step();
    s_req_valid = '0;
    send_ack(); mc[g2]++; rp = (g2 + 1) % P;
  endtask
  task automatic test_resp_route;
    s_resp_tag = {2'd3, 8'h7A}; s_resp_op_tag = 8'h9C; s_resp_valid = 1'b1; m_resp_ready = 4'b0111;
    #1;
    checks++; if (m_resp_valid !== 4'b1000) $display("FAIL resp_valid: got %b want 1000", m_resp_valid); else passed++;
    checks++; if (s_resp_ready !== 1'b0) $display("FAIL resp_ready_blocked: got %b want 0", s_resp_ready); else passed++;
    checks++; if (m_resp_tag !== 8'h7A) $display("FAIL resp_tag: got %h want 7a", m_resp_tag); else passed++;
    checks++; if (m_resp_op_tag !== 8'h9C) $display("FAIL resp_op_tag: got %h want 9c", m_resp_op_tag); else passed++;
    m_resp_ready = 4'b1000;
    #1;
    checks++; if (s_resp_ready !== 1'b1) $display("FAIL resp_ready_open: got %b want 1", s_resp_ready); else passed++;
    s_resp_valid = 1'b0;
    #1;
    checks++; if (m_resp_valid !== 4'b0000) $display("FAIL resp_idle: got %b want 0000", m_resp_valid); else passed++;
    m_resp_ready = '0;
  endtask
  task automatic test_credit;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      s_req_tag[1*RW +: RW] = 8'(i);
      s_req_valid = 4'b0010;
      #1;
      checks++; if (s_req_ready !== 4'b0010) $display("FAIL credit_ready_%0d: got %b want 0010", i, s_req_ready); else passed++;
      step();
      s_req_valid = '0;
      send_ack(); mc[1]++; rp = 2;
    end
    checks++; if (outstanding[1*CW +: CW] !== CW'(mc[1])) $display("FAIL credit_full_count: got %0d want %0d", outstanding[1*CW +: CW], mc[1]); else passed++;
    s_req_valid = 4'b0010;
    #1;
    checks++; if (s_req_ready !== 4'b0000) $display("FAIL credit_ninth_blocked: got %b want 0000", s_req_ready); else passed++;
    step();
    #1;
    checks++; if (m_req_valid !== 1'b0) $display("FAIL credit_no_send: got %b want 0", m_req_valid); else passed++;
    s_commit_op_tag[1*OW +: OW] = 8'h44; s_commit_valid = 4'b0010;
    #1;
    checks++; if (s_commit_ready !== 4'b0010) $display("FAIL credit_commit_ready: got %b want 0010", s_commit_ready); else passed++;
    step();
    s_commit_valid = '0; mc[1]--; cp = 2;
    #1;
    checks++; if (m_commit_valid !== 1'b1) $display("FAIL credit_commit_valid: got %b want 1", m_commit_valid); else passed++;
    checks++; if (m_commit_op_tag !== 8'h44) $display("FAIL credit_commit_tag: got %h want 44", m_commit_op_tag); else passed++;
    checks++; if (outstanding[1*CW +: CW] !== CW'(mc[1])) $display("FAIL credit_after_commit: got %0d want %0d", outstanding[1*CW +: CW], mc[1]); else passed++;
    checks++; if (s_req_ready !== 4'b0010) $display("FAIL credit_ninth_accept: got %b want 0010", s_req_ready); else passed++;
    step();
    s_req_valid = '0;
    send_ack(); mc[1]++; rp = 2;
    checks++; if (outstanding[1*CW +: CW] !== CW'(mc[1])) $display("FAIL credit_refill: got %0d want %0d", outstanding[1*CW +: CW], mc[1]); else passed++;
  endtask
  task automatic test_full_concurrent;
    do_reset();
    enable = 1'b1;
    repeat (2) begin
      s_req_valid = 4'b0010;
      step();
      s_req_valid = '0;
      send_ack(); mc[1]++; rp = 2;
    end
    s_req_valid = 4'b0010;
    s_resp_tag = {2'd1, 8'h11}; s_resp_full = 1'b1; s_resp_valid = 1'b1; m_resp_ready = 4'b0010;
    #1;
    checks++; if (s_req_ready !== 4'b0010) $display("FAIL full_req_ready: got %b want 0010", s_req_ready); else passed++;
    step();
    s_req_valid = '0; s_resp_valid = 1'b0; s_resp_full = 1'b0;
    send_ack(); rp = 2;
    checks++; if (outstanding[1*CW +: CW] !== CW'(mc[1])) $display("FAIL full_unchanged: got %0d want %0d", outstanding[1*CW +: CW], mc[1]); else passed++;
    s_resp_tag = {2'd0, 8'h22}; s_resp_error = 1'b1; s_resp_valid = 1'b1; m_resp_ready = 4'b0001;
    step();
    s_resp_valid = 1'b0;
    #1;
    checks++; if (outstanding[0 +: CW] !== CW'(mc[0])) $display("FAIL error_saturate: got %0d want %0d", outstanding[0 +: CW], mc[0]); else passed++;
    s_resp_tag = {2'd1, 8'h23}; s_resp_valid = 1'b1; m_resp_ready = 4'b0010;
    step();
    s_resp_valid = 1'b0; s_resp_error = 1'b0; m_resp_ready = '0;
    mc[1]--;
    #1;
    checks++; if (outstanding[1*CW +: CW] !== CW'(mc[1])) $display("FAIL error_dec: got %0d want %0d", outstanding[1*CW +: CW], mc[1]); else passed++;
  endtask
  task automatic test_random;
    int eg, ec;
    logic [P-1:0] vm, cm, el;
    logic [QW-1:0] eq;
    logic [TW-1:0] et;
    logic [OW-1:0] eo;
    for (int it = 0; it < 60; it++) begin
      vm = 4'($urandom);
      cm = 4'($urandom & $urandom);
      enable = ($urandom_range(0, 7) != 0);
      s_req_queue = (P*QW)'($urandom);
      s_req_tag = $urandom;
      s_commit_op_tag = $urandom;
      for (int p = 0; p < P; p++) el[p] = vm[p] && (mc[p] < MAXO);
      eg = enable ? rr_pick(el, rp) : -1;
      ec = rr_pick(cm, cp);
      eq = '0; et = '0; eo = '0;
      if (eg >= 0) begin eq = s_req_queue[eg*QW +: QW]; et = {2'(eg), s_req_tag[eg*RW +: RW]}; end
      if (ec >= 0) eo = s_commit_op_tag[ec*OW +: OW];
      s_req_valid = vm; s_commit_valid = cm;
      #1;
      checks++; if (s_req_ready !== onehot(eg)) $display("FAIL rand_req_ready it%0d: got %b want %b", it, s_req_ready, onehot(eg)); else passed++;
      checks++; if (s_commit_ready !== onehot(ec)) $display("FAIL rand_commit_ready it%0d: got %b want %b", it, s_commit_ready, onehot(ec)); else passed++;
      step();
      s_req_valid = '0; s_commit_valid = '0; enable = 1'b1;
      for (int p = 0; p < P; p++) begin
        mc[p] = mc[p] + (p == eg ? 1 : 0) - (p == ec ? 1 : 0);
        if (mc[p] < 0) mc[p] = 0;
      end
      if (ec >= 0) cp = (ec + 1) % P;
      #1;
      checks++; if (m_commit_valid !== (ec >= 0)) $display("FAIL rand_commit_valid it%0d: got %b want %b", it, m_commit_valid, ec >= 0); else passed++;
      if (ec >= 0) begin
        checks++; if (m_commit_op_tag !== eo) $display("FAIL rand_commit_tag it%0d: got %h want %h", it, m_commit_op_tag, eo); else passed++;
      end
      checks++; if (m_req_valid !== (eg >= 0)) $display("FAIL rand_req_valid it%0d: got %b want %b", it, m_req_valid, eg >= 0); else passed++;
      if (eg >= 0) begin
        checks++; if (m_req_tag !== et) $display("FAIL rand_req_tag it%0d: got %h want %h", it, m_req_tag, et); else passed++;
        checks++; if (m_req_queue !== eq) $display("FAIL rand_req_queue it%0d: got %h want %h", it, m_req_queue, eq); else passed++;
        repeat ($urandom_range(0, 2)) step();
        send_ack();
        rp = (eg + 1) % P;
      end
      for (int p = 0; p < P; p++) begin
        checks++; if (outstanding[p*CW +: CW] !== CW'(mc[p])) $display("FAIL rand_count it%0d port%0d: got %0d want %0d", it, p, outstanding[p*CW +: CW], mc[p]); else passed++;
      end
    end
  endtask
  task automatic test_reset_mid_send;
    do_reset();
    enable = 1'b1;
    s_req_valid = 4'b0100;
    step();
    s_req_valid = '0;
    send_ack(); mc[2]++; rp = 3;
    s_req_tag = 32'hA1B2C3D4; s_req_queue = 20'hABCDE;
    s_req_valid = 4'b1111;
    step();
    s_req_valid = '0;
    #1;
    checks++; if (m_req_valid !== 1'b1) $display("FAIL rst_mid_in_send: got %b want 1", m_req_valid); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (m_req_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", m_req_valid); else passed++;
    checks++; if (m_req_tag !== '0) $display("FAIL rst_mid_tag: got %h want 0", m_req_tag); else passed++;
    checks++; if (m_req_queue !== '0) $display("FAIL rst_mid_queue: got %h want 0", m_req_queue); else passed++;
    checks++; if (outstanding !== '0) $display("FAIL rst_mid_counts: got %h want 0", outstanding); else passed++;
    step();
    rst = 1'b0;
    for (int p = 0; p < P; p++) mc[p] = 0;
    rp = 0; cp = 0;
    step();
    #1;
    checks++; if (m_req_valid !== 1'b0) $display("FAIL rst_mid_dropped: got %b want 0", m_req_valid); else passed++;
    s_req_valid = 4'b1001;
    #1;
    checks++; if (s_req_ready !== onehot(rr_pick(4'b1001, rp))) $display("FAIL rst_mid_ptr: got %b want %b", s_req_ready, onehot(rr_pick(4'b1001, rp))); else passed++;
    step();
    s_req_valid = '0;
    send_ack();
  endtask
  initial begin
    test_reset();
    test_two_ports();
    test_stall();
    test_resp_route();
    test_credit();
    test_full_concurrent();
    test_random();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
